spi_master_mc: RTL

//  Parametrised SPI master: successor to the fixed 16-bit, mode-0, write-only DAC link.

---
 rtl/spi_master_mc.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_mc.sv
// Parametrised SPI master: one word per valid/ready handshake, MSB first, per-frame CPOL/CPHA,
// active-low chip selects and MISO readback. Every output is a flop loaded from next-state values.
module spi_master_mc #(
    parameter int DATA_W   = 16,
    parameter int DIV      = 10,
    parameter int NCS      = 2,
    parameter int CS_W     = 1,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [CS_W-1:0]   tx_cs_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic              sck_o,
    output logic [NCS-1:0]    ncs_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              cs_err_o,
    output logic [2:0]        state_o
);
    // Handshake: a word is taken on a clock edge where tx_valid_i && tx_ready_o;
    // tx_ready_o is high only in IDLE and requests made while busy are dropped.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int M1      = (DIV > CS_SETUP) ? DIV : CS_SETUP;
    localparam int M2      = (M1 > CS_HOLD) ? M1 : CS_HOLD;
    localparam int CNT_MAX = (M2 > GAP) ? M2 : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;

    logic [NCS-1:0]    ncs_q, ncs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              cs_err_q, cs_err_d;
    logic              frame_act;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        cs_d    = cs_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid_i) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    tx_sh_d = tx_data_i;
                    cs_d    = tx_cs_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == HALF) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
                // The shift at the end of a bit period presents the next bit at cnt 0.
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b1};
                    if (bit_q == BIT_LAST) state_d = S_HOLD;
                    else bit_d = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_act = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        ncs_d = '1;
        for (int i = 0; i < NCS; i++) begin
            if (frame_act && (cs_d == CS_W'(i))) ncs_d[i] = 1'b0;
        end
        sck_d = cpol_d;
        if (state_d == S_SHIFT) begin
            if (cpha_d ? (cnt_d < HALF) : (cnt_d >= HALF)) sck_d = ~cpol_d;
        end
        mosi_d = 1'b1;
        if ((state_d == S_SETUP) || (state_d == S_SHIFT)) mosi_d = tx_sh_d[DATA_W-1];
        busy_d     = (state_d != S_IDLE);
        ready_d    = (state_d == S_IDLE);
        rx_valid_d = (state_d == S_HOLD) && (cnt_d == HOLD_LAST);
        rx_data_d  = rx_valid_d ? rx_sh_d : rx_data_q;
        cs_err_d   = rx_valid_d && (int'(cs_d) >= NCS);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cs_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            ncs_q      <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            cs_q       <= cs_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            ncs_q      <= ncs_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_err_q   <= cs_err_d;
        end
    end

    assign tx_ready_o = ready_q;
    assign mosi_o     = mosi_q;
    assign sck_o      = sck_q;
    assign ncs_o      = ncs_q;
    assign busy_o     = busy_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign cs_err_o   = cs_err_q;
    assign state_o    = state_q;
endmodule
